// File: rtl/mips16_trace_capture.sv
// Commit-trace tap for MIPS16: records {pc, result} on every new PC into a show-ahead FIFO, flags a halted core.
// Entry visible one cycle after the sampling edge; when full with no pop the record is dropped and counted.
module mips16_trace_capture #(
   parameter int PC_W        = 16,
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 16,
   parameter int HALT_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PC_W-1:0]          pc_in,
   input  logic [DATA_W-1:0]        result_in,
   input  logic                     cap_en,
   input  logic                     clr,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [PC_W-1:0]          rd_pc,
   output logic [DATA_W-1:0]        rd_result,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               drop_cnt,
   output logic                     overflow,
   output logic                     halted
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(HALT_CYCLES + 1);
   localparam int EW = PC_W + DATA_W;
   localparam logic [SW-1:0] HALT_LAST = SW'(HALT_CYCLES - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
   logic              prev_valid_q, prev_valid_d;
   logic [SW-1:0]     stable_q, stable_d;
   logic              rec_evt;

   logic [EW-1:0]     mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [7:0]        drop_q, drop_d;
   logic              ovf_q, ovf_d;
   logic              empty, full, push, pop, drop;
   logic [EW-1:0]     head;

   always_comb begin
      state_d      = state_q;
      prev_pc_d    = prev_pc_q;
      prev_valid_d = prev_valid_q;
      stable_d     = stable_q;
      rec_evt      = 1'b0;
      if (!cap_en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d      = S_RUN;
               prev_valid_d = 1'b0;
            end
            S_RUN: begin
               if (!prev_valid_q || pc_in != prev_pc_q) begin
                  rec_evt = 1'b1;
               end else if (stable_q == HALT_LAST) begin
                  state_d = S_HALTED;
               end else begin
                  stable_d = stable_q + SW'(1);
               end
            end
            S_HALTED: begin
               if (pc_in != prev_pc_q) begin
                  rec_evt = 1'b1;
                  state_d = S_RUN;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (rec_evt) begin
         prev_pc_d    = pc_in;
         prev_valid_d = 1'b1;
         stable_d     = '0;
      end
   end

   // clr wins over any same-cycle push or pop; a pop frees the slot a full-FIFO push needs
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign pop   = !empty && rd_ready && !clr;
   assign push  = rec_evt && !clr && (!full || pop);
   assign drop  = rec_evt && !clr && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         drop_d   = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + (AW + 1)'(1);
         else if (pop && !push) count_d = count_q - (AW + 1)'(1);
         if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         prev_pc_q    <= '0;
         prev_valid_q <= 1'b0;
         stable_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         drop_q       <= '0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_pc_q    <= prev_pc_d;
         prev_valid_q <= prev_valid_d;
         stable_q     <= stable_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         drop_q       <= drop_d;
         ovf_q        <= ovf_d;
      end
   end

   // storage needs no reset: the head is masked to zero whenever the FIFO is empty
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {pc_in, result_in};
   end

   assign head      = mem_q[rd_ptr_q];
   assign rd_valid  = !empty;
   assign rd_pc     = empty ? '0 : head[EW-1:DATA_W];
   assign rd_result = empty ? '0 : head[DATA_W-1:0];
   assign count     = count_q;
   assign drop_cnt  = drop_q;
   assign overflow  = ovf_q;
   assign halted    = (state_q == S_HALTED);

endmodule
